// File: rtl/serial_word_packer.sv
// Serial-to-parallel packer: 32 data bits (MSB first) plus one function bit, presented under valid/ready.
// Optional odd-parity trailer bit is enabled by defining PACKER_PARITY_EN.
module serial_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic [31:0] date,
    output logic        fun,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  count,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        FUNC = 3'd2,
        PAR  = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] date_r;
    logic        fun_r;
    logic [5:0]  count_r;
    logic        out_valid_r;
    logic        bit_ready_r;
    logic        frame_err_r;

`ifdef PACKER_PARITY_EN
    // Odd parity holds when the total number of ones across word, function bit and parity bit is odd.
    function automatic logic odd_parity_ok(input logic [31:0] d, input logic f, input logic p);
        return ^{d, f, p};
    endfunction
`endif

    // Frame assembly FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            date_r      <= 32'd0;
            fun_r       <= 1'b0;
            count_r     <= 6'd0;
            out_valid_r <= 1'b0;
            bit_ready_r <= 1'b1;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bit_valid) begin
                        date_r  <= {date_r[30:0], bit_in};
                        count_r <= 6'd1;
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        date_r  <= {date_r[30:0], bit_in};
                        count_r <= count_r + 6'd1;
                        if (count_r == 6'd31) begin
                            state_r <= FUNC;
                        end
                    end
                end
                FUNC: begin
                    if (bit_valid) begin
                        fun_r   <= bit_in;
                        count_r <= 6'd33;
`ifdef PACKER_PARITY_EN
                        state_r <= PAR;
`else
                        state_r     <= HOLD;
                        out_valid_r <= 1'b1;
                        bit_ready_r <= 1'b0;
`endif
                    end
                end
`ifdef PACKER_PARITY_EN
                PAR: begin
                    if (bit_valid) begin
                        if (odd_parity_ok(date_r, fun_r, bit_in)) begin
                            count_r     <= 6'd34;
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                            bit_ready_r <= 1'b0;
                        end else begin
                            // A bad frame is dropped silently apart from the error pulse.
                            count_r     <= 6'd0;
                            state_r     <= IDLE;
                            frame_err_r <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        count_r     <= 6'd0;
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        bit_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    count_r     <= 6'd0;
                    out_valid_r <= 1'b0;
                    bit_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bit_ready = bit_ready_r;
    assign date      = date_r;
    assign fun       = fun_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
`ifdef PACKER_PARITY_EN
    assign frame_err = frame_err_r;
`else
    assign frame_err = 1'b0;
`endif

endmodule
